// File: rtl/dma_mem_ctrl.sv
// dma_mem_ctrl: word-copy DMA engine that shares the single data-memory port with the MEM stage.
// Latency: ack 3N+1 cycles after the accepting edge with an idle CPU; port arbitration is combinational.
// Backpressure: CPU has priority and is stalled only on a DMA grant; DMA_FAIR_EN forces a grant after MAX_WAIT denials.
module dma_mem_ctrl #(
  parameter int LEN_W = 16
`ifdef DMA_FAIR_EN
  , parameter int MAX_WAIT = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nextTransaction,
  input  logic [31:0]      dma_src,
  input  logic [31:0]      dma_dst,
  input  logic [LEN_W-1:0] dma_len,
  output logic             ack,
  output logic             en,
  input  logic             cpu_memrd,
  input  logic             cpu_memwr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      src, dst, dbuf;
  logic [LEN_W-1:0] cnt;
  logic             cpu_req, dma_req, grant_dma, force_grant;

  assign cpu_req   = cpu_memrd | cpu_memwr;
  assign dma_req   = (state == RD) || (state == WR);
  assign grant_dma = dma_req & (~cpu_req | force_grant);
  assign cpu_stall = grant_dma & cpu_req;
  assign cpu_rdata = mem_rdata;
  assign ack       = (state == DONE);
  assign en        = (state == RD) || (state == CAP) || (state == WR);

`ifdef DMA_FAIR_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  // Counts consecutive denied DMA cycles; any grant (forced or free) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (grant_dma) begin
      wait_cnt <= '0;
    end else if (dma_req && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign force_grant = (wait_cnt == WAIT_W'(MAX_WAIT));
`else
  assign force_grant = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;

    case (state)
      IDLE:    if (nextTransaction) state_nxt = (dma_len != '0) ? RD : DONE;
      RD:      if (grant_dma) state_nxt = CAP;
      CAP:     state_nxt = WR;
      WR:      if (grant_dma) state_nxt = (cnt == LEN_W'(1)) ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Port mux: DMA only when granted, otherwise the MEM stage (write wins over read).
    if (grant_dma) begin
      if (state == RD) begin
        mem_rd   = 1'b1;
        mem_addr = src;
      end else begin
        mem_wr    = 1'b1;
        mem_addr  = dst;
        mem_wdata = dbuf;
      end
    end else begin
      mem_wr = cpu_memwr;
      mem_rd = cpu_memrd & ~cpu_memwr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src  <= '0;
      dst  <= '0;
      cnt  <= '0;
      dbuf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (nextTransaction) begin
            src <= {dma_src[31:2], 2'b00};
            dst <= {dma_dst[31:2], 2'b00};
            cnt <= dma_len;
          end
        end
        CAP: dbuf <= mem_rdata;
        WR: begin
          if (grant_dma) begin
            src <= src + 32'd4;
            dst <= dst + 32'd4;
            cnt <= cnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Testbench for dma_mem_ctrl: directed transfers against a memory model, with a read/write scoreboard
// filled when a transfer is requested and drained as the DMA engine drives the memory port.
module tb_dma_mem_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             nextTransaction = 1'b0;
  logic [31:0]      dma_src = '0;
  logic [31:0]      dma_dst = '0;
  logic [LEN_W-1:0] dma_len = '0;
  logic             ack, en;
  logic             cpu_memrd = 1'b0;
  logic             cpu_memwr = 1'b0;
  logic [31:0]      cpu_addr = 32'h0000_0900;
  logic [31:0]      cpu_wdata = '0;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_rd, mem_wr;
  logic [31:0]      mem_rdata = '0;

  int checks = 0;
  int passes = 0;

  logic [31:0] rdq[$];
  logic [31:0] wrq[$];
  logic [31:0] wdq[$];
  logic [31:0] mem_words[logic [31:0]];

  dma_mem_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .nextTransaction(nextTransaction),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
    .ack(ack), .en(en),
    .cpu_memrd(cpu_memrd), .cpu_memwr(cpu_memwr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory model: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_wr) mem_words[mem_addr] = mem_wdata;
    if (mem_rd) mem_rdata <= mem_words.exists(mem_addr) ? mem_words[mem_addr] : pat(mem_addr);
  end

  logic [31:0] mon_a, mon_d;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((cpu_memrd || cpu_memwr) && !cpu_stall) begin
        check("cpu_port_addr", mem_addr, cpu_addr);
        check("cpu_port_rd", {31'b0, mem_rd}, {31'b0, cpu_memrd & ~cpu_memwr});
      end else begin
        if (mem_rd) begin
          if (rdq.size() != 0) mon_a = rdq.pop_front();
          else mon_a = 'x;
          check("dma_rd_addr", mem_addr, mon_a);
        end
        if (mem_wr) begin
          if (wrq.size() != 0) begin
            mon_a = wrq.pop_front();
            mon_d = wdq.pop_front();
          end else begin
            mon_a = 'x;
            mon_d = 'x;
          end
          check("dma_wr_addr", mem_addr, mon_a);
          check("dma_wr_data", mem_wdata, mon_d);
        end
      end
    end
  end

  task automatic start(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      rdq.push_back(sa + 32'(4 * i));
      wrq.push_back(da + 32'(4 * i));
      wdq.push_back(pat(sa + 32'(4 * i)));
    end
    @(posedge clk);
    #1;
    dma_src = s;
    dma_dst = d;
    dma_len = LEN_W'(n);
    nextTransaction = 1'b1;
    @(posedge clk);
    #1;
    nextTransaction = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accepting edge.
  task automatic wait_ack(output int ack_cyc, output int en_cnt, output int strobes,
                          output int stall_cnt, output int first_stall);
    ack_cyc = -1; en_cnt = 0; strobes = 0; stall_cnt = 0; first_stall = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (en) en_cnt++;
      if (cpu_stall) begin
        stall_cnt++;
        if (first_stall < 0) first_stall = c;
      end
      if (!cpu_memrd && !cpu_memwr && (mem_rd || mem_wr)) strobes++;
      if (ack) begin
        ack_cyc = c;
        break;
      end
    end
    @(negedge clk);
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rdq_empty"}, 32'(rdq.size()), 32'd0);
    check({tag, "_wrq_empty"}, 32'(wrq.size()), 32'd0);
  endtask

  initial begin
    int ac, ec, sc, st, fs, acks;

    #12;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_en", {31'b0, en}, 32'd0);
    check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Three-word copy with an idle CPU
    start(32'h0000_0100, 32'h0000_0200, 3);
    wait_ack(ac, ec, sc, st, fs);
    check("t1_ack_cycle", ac, 32'd10);
    check("t1_en_cycles", ec, 32'd9);
    check("t1_dma_strobes", sc, 32'd6);
    check_drained("t1");

    // Zero-length transfer
    start(32'h0000_0700, 32'h0000_0800, 0);
    wait_ack(ac, ec, sc, st, fs);
    check("t2_ack_cycle", ac, 32'd1);
    check("t2_en_cycles", ec, 32'd0);
    check("t2_dma_strobes", sc, 32'd0);

    // Unaligned source and destination wrapping through 2^32
    start(32'h0000_0103, 32'hFFFF_FFFC, 2);
    wait_ack(ac, ec, sc, st, fs);
    check("t5_ack_cycle", ac, 32'd7);
    check("t5_dma_strobes", sc, 32'd4);
    check_drained("t5");

`ifdef DMA_FAIR_EN
    // CPU reads every cycle; DMA must be forced in after 8 denials on each access
    cpu_memrd = 1'b1;
    start(32'h0000_0500, 32'h0000_0600, 1);
    wait_ack(ac, ec, sc, st, fs);
    check("t3_ack_cycle", ac, 32'd20);
    check("t3_stall_cycles", st, 32'd2);
    check("t3_first_stall", fs, 32'd9);
    check("t3_en_cycles", ec, 32'd19);
    cpu_memrd = 1'b0;
    check_drained("t3");
`else
    // CPU reads every cycle; DMA starves until the CPU lets go
    cpu_memrd = 1'b1;
    start(32'h0000_0500, 32'h0000_0600, 1);
    st = 0;
    acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cpu_stall) st++;
      if (ack) acks++;
    end
    check("t4_no_stall", st, 32'd0);
    check("t4_no_ack", acks, 32'd0);
    check("t4_en_held", {31'b0, en}, 32'd1);
    check("t4_rd_pending", 32'(rdq.size()), 32'd1);
    @(posedge clk);
    #1 cpu_memrd = 1'b0;
    wait_ack(ac, ec, sc, st, fs);
    check("t4_ack_after_release", ac, 32'd4);
    check_drained("t4");
`endif

    // Asynchronous reset in the write of word 2 of 4
    start(32'h0000_0300, 32'h0000_0400, 4);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    check("t6_in_wr2", {31'b0, mem_wr}, 32'd1);
    check("t6_wr2_addr", mem_addr, 32'h0000_0404);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_en", {31'b0, en}, 32'd0);
    check("t6_rst_ack", {31'b0, ack}, 32'd0);
    check("t6_rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    rdq.delete();
    wrq.delete();
    wdq.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("t6_no_ack", acks, 32'd0);
    check("t6_idle_en", {31'b0, en}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
